// File: rtl/count_sampler_if.sv
// ============================================================================
// count_sampler_if : valid/ready output channel carrying settled count values.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface count_sampler_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] out_val;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_val, output out_valid, input out_ready);
  modport slave  (input out_val, input out_valid, output out_ready);
endinterface

`default_nettype wire

// File: rtl/count_sampler.sv
// ============================================================================
// count_sampler : synchronises and debounces a ripple down-counter, publishes
// settled values, flags wraps. Optional step checker: COUNT_SAMPLER_SEQCHK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_sampler #(
  parameter int WIDTH         = 5,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  wire logic              clk,
  input  wire logic              clear,
  input  wire logic [WIDTH-1:0]  cnt_in,
  count_sampler_if.master        out_if,
  output logic                   wrap,
  output logic [WRAP_W-1:0]      wrap_count,
  output logic                   overrun,
  output logic                   seq_err,
  output logic                   err_sticky
);

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;
  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  logic [WIDTH-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0]  cand_q, cand_d;
  logic [3:0]        stab_q, stab_d;
  logic [WIDTH-1:0]  last_q, last_d;
  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  out_val_q, out_val_d;
  logic              out_valid_q, out_valid_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic              overrun_q, overrun_d;
  logic              accept;
  logic              transfer;

  always_comb begin
    s1_d = cnt_in;
    s2_d = s1_q;
    // v1/v2 mark when s2 holds a real sample rather than its reset value,
    // so the cleared sync stages never masquerade as a settled zero.
    v1_d = 1'b1;
    v2_d = v1_q;

    cand_d = cand_q;
    stab_d = stab_q;
    if (v2_q) begin
      if (s2_q != cand_q) begin
        cand_d = s2_q;
        stab_d = 4'd1;
      end else if (stab_q != STAB_MAX) begin
        stab_d = stab_q + 4'd1;
      end
    end

    accept   = v2_q && (stab_d == STAB_MAX) &&
               ((state_q == ST_FIRST) || (cand_d != last_q));
    transfer = out_valid_q && out_if.out_ready;

    state_d      = state_q;
    last_d       = last_q;
    out_val_d    = out_val_q;
    out_valid_d  = transfer ? 1'b0 : out_valid_q;
    wrap_d       = 1'b0;
    wrap_count_d = wrap_count_q;
    overrun_d    = overrun_q;

    if (accept) begin
      last_d      = cand_d;
      out_val_d   = cand_d;
      out_valid_d = 1'b1;
      state_d     = ST_TRACK;
      if (out_valid_q && !out_if.out_ready) begin
        overrun_d = 1'b1;
      end
      if ((state_q == ST_TRACK) && (last_q == '0) && (cand_d == '1)) begin
        wrap_d = 1'b1;
        if (wrap_count_q != '1) begin
          wrap_count_d = wrap_count_q + WRAP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      s1_q         <= '0;
      s2_q         <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      cand_q       <= '0;
      stab_q       <= '0;
      last_q       <= '0;
      state_q      <= ST_FIRST;
      out_val_q    <= '0;
      out_valid_q  <= 1'b0;
      wrap_q       <= 1'b0;
      wrap_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      last_q       <= last_d;
      state_q      <= state_d;
      out_val_q    <= out_val_d;
      out_valid_q  <= out_valid_d;
      wrap_q       <= wrap_d;
      wrap_count_q <= wrap_count_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef COUNT_SAMPLER_SEQCHK_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic seq_err_q, seq_err_d;
  logic err_sticky_q, err_sticky_d;

  // The modular decrement makes 0 -> all-ones a legal step.
  always_comb begin
    seq_err_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    if (accept && (state_q == ST_TRACK) && (cand_d != (last_q - ONE))) begin
      seq_err_d    = 1'b1;
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      seq_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      seq_err_q    <= seq_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign seq_err    = seq_err_q;
  assign err_sticky = err_sticky_q;
`else
  assign seq_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

  assign out_if.out_val   = out_val_q;
  assign out_if.out_valid = out_valid_q;
  assign wrap             = wrap_q;
  assign wrap_count       = wrap_count_q;
  assign overrun          = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_count_sampler.sv
// ============================================================================
// tb_count_sampler : directed self-checking bench for count_sampler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_sampler;

  localparam int WIDTH  = 5;
  localparam int WRAP_W = 8;
`ifdef COUNT_SAMPLER_SEQCHK_EN
  localparam int SEQ_EN = 1;
`else
  localparam int SEQ_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              clear = 1'b0;
  logic [WIDTH-1:0]  cnt_in = '0;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_count;
  logic              overrun;
  logic              seq_err;
  logic              err_sticky;

  int nchk  = 0;
  int nfail = 0;

  int nv, lastv, saw8, wrapv, wraps, seqs;

  logic [WIDTH-1:0] vals [6];

  count_sampler_if #(.WIDTH(WIDTH)) bus ();

  count_sampler #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(2),
    .WRAP_W       (WRAP_W)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .cnt_in    (cnt_in),
    .out_if    (bus.master),
    .wrap      (wrap),
    .wrap_count(wrap_count),
    .overrun   (overrun),
    .seq_err   (seq_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    nv = 0; lastv = -1; saw8 = 0; wrapv = 0; wraps = 0; seqs = 0;
  endtask

  // Drive v for n cycles, sampling outputs on each falling edge.
  task automatic watch(input logic [WIDTH-1:0] v, input int n);
    cnt_in = v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        nv++;
        lastv = int'(bus.out_val);
        if (bus.out_val == 5'd8) saw8++;
        if (wrap) wrapv++;
      end
      if (wrap) wraps++;
      if (seq_err) seqs++;
    end
  endtask

  task automatic reset_pulse(input logic [WIDTH-1:0] v);
    clear  = 1'b0;
    cnt_in = v;
    repeat (2) @(negedge clk);
    clear  = 1'b1;
  endtask

  initial begin
    int wsum;
    int sseq;
    vals[0] = 5'd3;  vals[1] = 5'd2;  vals[2] = 5'd1;
    vals[3] = 5'd0;  vals[4] = 5'd31; vals[5] = 5'd30;
    bus.out_ready = 1'b0;
    clear  = 1'b0;
    cnt_in = 5'd17;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_wrap_count", wrap_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_err_sticky", err_sticky, 0);

    // First-accept latency: 4 rising edges after release
    clear = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_edge3_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_edge4_valid", bus.out_valid, 1);
    chk("lat_edge4_val", bus.out_val, 17);
    chk("lat_edge4_wrap", wrap, 0);

    // Decrement run through the wrap
    bus.out_ready = 1'b1;
    reset_pulse(5'd3);
    wsum = 0;
    sseq = 0;
    for (int k = 0; k < 6; k++) begin
      clr_stats();
      watch(vals[k], 8);
      chk("run_valid_count", nv, 1);
      chk("run_val", lastv, int'(vals[k]));
      chk("run_wrap_with_val", wrapv, (k == 4) ? 1 : 0);
      wsum += wraps;
      sseq += seqs;
    end
    chk("run_wrap_pulses", wsum, 1);
    chk("run_wrap_count", wrap_count, 1);
    chk("run_seq_err", sseq, 0);
    chk("run_err_sticky", err_sticky, 0);

    // Glitch rejection
    reset_pulse(5'd10);
    clr_stats();
    watch(5'd10, 8);
    chk("gl_first_count", nv, 1);
    chk("gl_first_val", lastv, 10);
    clr_stats();
    watch(5'd8, 1);
    watch(5'd9, 8);
    chk("gl_valid_count", nv, 1);
    chk("gl_val", lastv, 9);
    chk("gl_saw8", saw8, 0);

    // Overrun
    bus.out_ready = 1'b0;
    reset_pulse(5'd20);
    clr_stats();
    watch(5'd20, 8);
    chk("ov_first_valid", bus.out_valid, 1);
    chk("ov_first_val", bus.out_val, 20);
    chk("ov_first_overrun", overrun, 0);
    watch(5'd19, 8);
    chk("ov_val", bus.out_val, 19);
    chk("ov_valid", bus.out_valid, 1);
    chk("ov_overrun", overrun, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("ov_drain_valid", bus.out_valid, 0);
    chk("ov_drain_overrun", overrun, 1);
    @(negedge clk);
    chk("ov_hold_valid", bus.out_valid, 0);

    // Sequence error 12 -> 9
    bus.out_ready = 1'b1;
    reset_pulse(5'd12);
    clr_stats();
    watch(5'd12, 8);
    chk("seq_first_val", lastv, 12);
    clr_stats();
    watch(5'd9, 8);
    chk("seq_valid_count", nv, 1);
    chk("seq_val", lastv, 9);
    chk("seq_pulses", seqs, SEQ_EN);
    chk("seq_err_now", seq_err, 0);
    chk("seq_sticky", err_sticky, SEQ_EN);

    // Reset mid-transfer, then 0 -> 31 as a FIRST accept
    bus.out_ready = 1'b0;
    clr_stats();
    watch(5'd8, 8);
    chk("mid_valid_before", bus.out_valid, 1);
    chk("mid_val_before", bus.out_val, 8);
    #2;
    clear  = 1'b0;
    cnt_in = 5'd0;
    #1;
    chk("mid_async_valid", bus.out_valid, 0);
    chk("mid_async_val", bus.out_val, 0);
    chk("mid_async_sticky", err_sticky, 0);
    repeat (2) @(negedge clk);
    clear  = 1'b1;
    bus.out_ready = 1'b1;
    clr_stats();
    watch(5'd31, 8);
    chk("post_valid_count", nv, 1);
    chk("post_val", lastv, 31);
    chk("post_wrap_pulses", wraps, 0);
    chk("post_wrap_count", wrap_count, 0);
    chk("post_seq_pulses", seqs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire
